// File: rtl/lab2_proc_imem_fetch_unit.sv
// Instruction-fetch front end: credit-limited imem requests tagged with their PC,
// squash-aware response dropping, and a small response FIFO feeding the D stage.
module lab2_proc_imem_fetch_unit #(
  parameter int p_num_entries  = 2,
  parameter int p_max_inflight = 2
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  fetch_req_val,
  output logic                                  fetch_req_rdy,
  input  logic [31:0]                           fetch_req_addr,
  input  logic                                  squash,
  output logic                                  imem_req_val,
  input  logic                                  imem_req_rdy,
  output logic [31:0]                           imem_req_addr,
  input  logic                                  imem_resp_val,
  output logic                                  imem_resp_rdy,
  input  logic [31:0]                           imem_resp_data,
  output logic                                  inst_val,
  input  logic                                  inst_rdy,
  output logic [31:0]                           inst_data,
  output logic [31:0]                           inst_pc,
  output logic [$clog2(p_max_inflight+1)-1:0]   inflight
);

  localparam int IW = $clog2(p_max_inflight + 1);
  localparam int PW = $clog2(p_num_entries);
  localparam int OW = PW + 1;
  localparam int TW = (p_max_inflight > 1) ? $clog2(p_max_inflight) : 1;
  localparam logic [31:0] MAXI = p_max_inflight;
  localparam logic [31:0] NENT = p_num_entries;
  localparam logic [TW-1:0] TLAST = TW'(p_max_inflight - 1);

  logic [IW-1:0] inflight_q, inflight_d;
  logic [IW-1:0] drop_q, drop_d;
  logic [OW-1:0] wr_q, wr_d, rd_q, rd_d, occ;
  logic [TW-1:0] tq_wr_q, tq_wr_d, tq_rd_q, tq_rd_d;

  logic [31:0] tag_q      [p_max_inflight];
  logic [31:0] buf_data_q [p_num_entries];
  logic [31:0] buf_pc_q   [p_num_entries];

  logic credit_ok, req_fire, resp_fire, drop, enq, deq, empty;

  function automatic logic [TW-1:0] tq_inc(input logic [TW-1:0] p);
    return (p == TLAST) ? '0 : p + TW'(1);
  endfunction

  // Occupancy uses the extra pointer bit so a full buffer differs from an empty one.
  assign occ       = wr_q - rd_q;
  assign empty     = (occ == '0);
  assign credit_ok = (32'(inflight_q) < MAXI) &&
                     ((32'(inflight_q) + 32'(occ)) < NENT);

  assign imem_req_val  = reset & fetch_req_val & credit_ok;
  assign fetch_req_rdy = reset & imem_req_rdy & credit_ok;
  assign imem_req_addr = fetch_req_addr;
  assign imem_resp_rdy = reset;

  assign req_fire  = imem_req_val & imem_req_rdy;
  assign resp_fire = imem_resp_val & imem_resp_rdy;
  assign drop      = (drop_q != '0) | squash;
  assign enq       = resp_fire & ~drop;

  assign inst_val  = reset & ~empty & ~squash;
  assign deq       = inst_val & inst_rdy;
  assign inst_data = empty ? '0 : buf_data_q[rd_q[PW-1:0]];
  assign inst_pc   = empty ? '0 : buf_pc_q[rd_q[PW-1:0]];
  assign inflight  = inflight_q;

  always_comb begin
    inflight_d = inflight_q + IW'(req_fire) - IW'(resp_fire);
    drop_d     = drop_q;
    wr_d       = wr_q + OW'(enq);
    rd_d       = rd_q + OW'(deq);
    tq_wr_d    = req_fire  ? tq_inc(tq_wr_q) : tq_wr_q;
    tq_rd_d    = resp_fire ? tq_inc(tq_rd_q) : tq_rd_q;
    // Every request already outstanding at a redirect is older than it; a
    // same-cycle request is the redirect target and is not counted.
    if (squash) begin
      drop_d = inflight_q - IW'(resp_fire);
      rd_d   = wr_q;
    end else if (resp_fire && (drop_q != '0)) begin
      drop_d = drop_q - IW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inflight_q <= '0;
      drop_q     <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      tq_wr_q    <= '0;
      tq_rd_q    <= '0;
    end else begin
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      tq_wr_q    <= tq_wr_d;
      tq_rd_q    <= tq_rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (req_fire) tag_q[tq_wr_q] <= fetch_req_addr;
    if (enq) begin
      buf_data_q[wr_q[PW-1:0]] <= imem_resp_data;
      buf_pc_q[wr_q[PW-1:0]]   <= tag_q[tq_rd_q];
    end
  end

endmodule
